mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 14 +
 rtl/mem_access_ctrl_mem_wb_reg.sv | 41 ++++
 rtl/mem_access_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-stage access controller: default widths,
// timeout budget and FSM state encoding.
package mem_access_ctrl_pkg;

   localparam int WORD_LEN_DEF          = 16;
   localparam int REG_FILE_ADDR_LEN_DEF = 4;
   localparam int TIMEOUT_CYCLES_DEF    = 15;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

endpackage

// File: rtl/mem_access_ctrl_mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears every field; a load captures the
// retiring op. With neither asserted the register holds.
module mem_wb_reg
   import mem_access_ctrl_pkg::*;
#(
   parameter int WORD_LEN          = WORD_LEN_DEF,
   parameter int REG_FILE_ADDR_LEN = REG_FILE_ADDR_LEN_DEF
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load,
   input  logic                         bubble,
   input  logic                         wb_en_d,
   input  logic                         mem_r_en_d,
   input  logic [REG_FILE_ADDR_LEN-1:0] dest_d,
   input  logic [WORD_LEN-1:0]          alu_res_d,
   input  logic [WORD_LEN-1:0]          mem_res_d,
   output logic                         wb_en,
   output logic                         mem_r_en,
   output logic [REG_FILE_ADDR_LEN-1:0] dest,
   output logic [WORD_LEN-1:0]          alu_res,
   output logic [WORD_LEN-1:0]          mem_res
);

   always_ff @(posedge clk) begin
      if (rst || bubble) begin
         wb_en    <= 1'b0;
         mem_r_en <= 1'b0;
         dest     <= '0;
         alu_res  <= '0;
         mem_res  <= '0;
      end else if (load) begin
         wb_en    <= wb_en_d;
         mem_r_en <= mem_r_en_d;
         dest     <= dest_d;
         alu_res  <= alu_res_d;
         mem_res  <= mem_res_d;
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: stalls the pipeline while a data-memory access is
// outstanding, retires the op into MEM/WB on ack, and gives up after a timeout.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int WORD_LEN          = WORD_LEN_DEF,
   parameter int REG_FILE_ADDR_LEN = REG_FILE_ADDR_LEN_DEF,
   parameter int TIMEOUT_CYCLES    = TIMEOUT_CYCLES_DEF
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         WB_EN_IN,
   input  logic                         MEM_R_EN_IN,
   input  logic                         MEM_W_EN_IN,
   input  logic [WORD_LEN-1:0]          ALUResIn,
   input  logic [WORD_LEN-1:0]          STValIn,
   input  logic [REG_FILE_ADDR_LEN-1:0] destIn,
   output logic                         freeze,
   output logic                         mem_req,
   output logic                         mem_we,
   output logic [WORD_LEN-1:0]          mem_addr,
   output logic [WORD_LEN-1:0]          mem_wdata,
   input  logic [WORD_LEN-1:0]          mem_rdata,
   input  logic                         mem_ack,
   output logic                         WB_EN,
   output logic                         MEM_R_EN,
   output logic [REG_FILE_ADDR_LEN-1:0] dest,
   output logic [WORD_LEN-1:0]          ALURes,
   output logic [WORD_LEN-1:0]          MEMRes,
   output logic                         mem_err
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   state_t                       state, next_state;
   logic [CNT_W-1:0]             cnt;
   logic                         lat_wb, lat_rd, lat_we;
   logic [REG_FILE_ADDR_LEN-1:0] lat_dest;
   logic [WORD_LEN-1:0]          lat_addr, lat_wdata;

   logic                         latch_en, cnt_inc, err_set;
   logic                         wb_load, wb_bubble, wb_en_d, mem_r_en_d;
   logic [REG_FILE_ADDR_LEN-1:0] dest_d;
   logic [WORD_LEN-1:0]          alu_res_d, mem_res_d;

   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_wb    <= 1'b0;
         lat_rd    <= 1'b0;
         lat_we    <= 1'b0;
         lat_dest  <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         mem_err   <= 1'b0;
      end else begin
         state <= next_state;
         // A simultaneous read+write is treated as a write; the read is dropped.
         if (latch_en) begin
            cnt       <= '0;
            lat_wb    <= WB_EN_IN;
            lat_rd    <= MEM_R_EN_IN & ~MEM_W_EN_IN;
            lat_we    <= MEM_W_EN_IN;
            lat_dest  <= destIn;
            lat_addr  <= ALUResIn;
            lat_wdata <= STValIn;
         end else if (cnt_inc) begin
            cnt <= cnt + 1'b1;
         end
         if (err_set)
            mem_err <= 1'b1;
      end
   end

   always_comb begin
      next_state = state;
      freeze     = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      latch_en   = 1'b0;
      cnt_inc    = 1'b0;
      err_set    = 1'b0;
      wb_load    = 1'b0;
      wb_bubble  = 1'b0;
      wb_en_d    = WB_EN_IN;
      mem_r_en_d = MEM_R_EN_IN;
      dest_d     = destIn;
      alu_res_d  = ALUResIn;
      mem_res_d  = '0;
      unique case (state)
         IDLE: begin
            if (MEM_R_EN_IN || MEM_W_EN_IN) begin
               freeze     = 1'b1;
               wb_bubble  = 1'b1;
               latch_en   = 1'b1;
               err_set    = MEM_R_EN_IN & MEM_W_EN_IN;
               next_state = ACCESS;
            end else begin
               wb_load = 1'b1;
            end
         end
         ACCESS: begin
            mem_req    = 1'b1;
            mem_we     = lat_we;
            mem_r_en_d = lat_rd;
            dest_d     = lat_dest;
            alu_res_d  = lat_addr;
            if (mem_ack) begin
               wb_load    = 1'b1;
               wb_en_d    = lat_wb;
               mem_res_d  = lat_rd ? mem_rdata : '0;
               next_state = IDLE;
            end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               // Timed out: retire the op harmlessly so the pipeline can move on.
               wb_load    = 1'b1;
               wb_en_d    = 1'b0;
               err_set    = 1'b1;
               next_state = IDLE;
            end else begin
               freeze    = 1'b1;
               wb_bubble = 1'b1;
               cnt_inc   = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   mem_wb_reg #(
      .WORD_LEN          (WORD_LEN),
      .REG_FILE_ADDR_LEN (REG_FILE_ADDR_LEN)
   ) u_mem_wb_reg (
      .clk        (clk),
      .rst        (rst),
      .load       (wb_load),
      .bubble     (wb_bubble),
      .wb_en_d    (wb_en_d),
      .mem_r_en_d (mem_r_en_d),
      .dest_d     (dest_d),
      .alu_res_d  (alu_res_d),
      .mem_res_d  (mem_res_d),
      .wb_en      (WB_EN),
      .mem_r_en   (MEM_R_EN),
      .dest       (dest),
      .alu_res    (ALURes),
      .mem_res    (MEMRes)
   );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl: pass-through, read, write,
// timeout, reset mid-access, illegal read+write and ack while idle.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN;
   logic [15:0] ALUResIn, STValIn;
   logic [3:0]  destIn;
   logic        freeze, mem_req, mem_we;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack;
   logic        WB_EN, MEM_R_EN;
   logic [3:0]  dest;
   logic [15:0] ALURes, MEMRes;
   logic        mem_err;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   mem_access_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .WB_EN_IN    (WB_EN_IN),
      .MEM_R_EN_IN (MEM_R_EN_IN),
      .MEM_W_EN_IN (MEM_W_EN_IN),
      .ALUResIn    (ALUResIn),
      .STValIn     (STValIn),
      .destIn      (destIn),
      .freeze      (freeze),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack),
      .WB_EN       (WB_EN),
      .MEM_R_EN    (MEM_R_EN),
      .dest        (dest),
      .ALURes      (ALURes),
      .MEMRes      (MEMRes),
      .mem_err     (mem_err)
   );

   task automatic applyStimulus(input logic wb, input logic rd, input logic wr,
                                input logic [15:0] alu, input logic [15:0] st,
                                input logic [3:0] d);
      WB_EN_IN    = wb;
      MEM_R_EN_IN = rd;
      MEM_W_EN_IN = wr;
      ALUResIn    = alu;
      STValIn     = st;
      destIn      = d;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0);
      tick();
      tick();
      checkOutput("rst_freeze",  {31'd0, freeze},  32'd0);
      checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
      checkOutput("rst_wb_en",   {31'd0, WB_EN},   32'd0);
      checkOutput("rst_alures",  {16'd0, ALURes},  32'd0);
      checkOutput("rst_mem_err", {31'd0, mem_err}, 32'd0);
      rst = 1'b0;

      // Non-memory op passes through with one cycle of latency.
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0012, 16'h0000, 4'd3);
      #1;
      checkOutput("nop_freeze", {31'd0, freeze}, 32'd0);
      tick();
      checkOutput("nop_alures", {16'd0, ALURes}, 32'h0012);
      checkOutput("nop_dest",   {28'd0, dest},   32'd3);
      checkOutput("nop_wb_en",  {31'd0, WB_EN},  32'd1);
      checkOutput("nop_memres", {16'd0, MEMRes}, 32'd0);
      checkOutput("nop_freeze2", {31'd0, freeze}, 32'd0);

      // Read acked on the first access cycle.
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000, 4'd5);
      #1;
      checkOutput("rd_idle_freeze", {31'd0, freeze},  32'd1);
      checkOutput("rd_idle_req",    {31'd0, mem_req}, 32'd0);
      tick();
      checkOutput("rd_bubble_wb",   {31'd0, WB_EN},    32'd0);
      checkOutput("rd_req",         {31'd0, mem_req},  32'd1);
      checkOutput("rd_we",          {31'd0, mem_we},   32'd0);
      checkOutput("rd_addr",        {16'd0, mem_addr}, 32'h0040);
      mem_ack   = 1'b1;
      mem_rdata = 16'hBEEF;
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0);
      #1;
      checkOutput("rd_ack_freeze",  {31'd0, freeze}, 32'd0);
      tick();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      checkOutput("rd_memres",   {16'd0, MEMRes},   32'hBEEF);
      checkOutput("rd_mem_r_en", {31'd0, MEM_R_EN}, 32'd1);
      checkOutput("rd_wb_en",    {31'd0, WB_EN},    32'd1);
      checkOutput("rd_dest",     {28'd0, dest},     32'd5);
      checkOutput("rd_alures",   {16'd0, ALURes},   32'h0040);
      checkOutput("rd_done_req", {31'd0, mem_req},  32'd0);

      // Write acked after three access cycles; freeze lasts four cycles.
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0008, 16'h1234, 4'd0);
      #1;
      checkOutput("wr_idle_freeze", {31'd0, freeze}, 32'd1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 4'd0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("wr_freeze", {31'd0, freeze},    32'd1);
         checkOutput("wr_we",     {31'd0, mem_we},    32'd1);
         checkOutput("wr_wdata",  {16'd0, mem_wdata}, 32'h1234);
         checkOutput("wr_addr",   {16'd0, mem_addr},  32'h0008);
         tick();
         checkOutput("wr_bubble_alures", {16'd0, ALURes}, 32'd0);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0);
      mem_ack   = 1'b1;
      mem_rdata = 16'hDEAD;
      #1;
      checkOutput("wr_ack_freeze", {31'd0, freeze}, 32'd0);
      tick();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      checkOutput("wr_alures", {16'd0, ALURes},  32'h0008);
      checkOutput("wr_memres", {16'd0, MEMRes},  32'd0);
      checkOutput("wr_wb_en",  {31'd0, WB_EN},   32'd0);
      checkOutput("wr_err",    {31'd0, mem_err}, 32'd0);

      // No ack: timeout after 15 access cycles.
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0000, 4'd7);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0);
      for (int i = 0; i < 14; i++) begin
         checkOutput("to_freeze", {31'd0, freeze},  32'd1);
         checkOutput("to_err",    {31'd0, mem_err}, 32'd0);
         tick();
      end
      checkOutput("to_last_freeze", {31'd0, freeze},  32'd0);
      checkOutput("to_last_req",    {31'd0, mem_req}, 32'd1);
      tick();
      checkOutput("to_wb_en",   {31'd0, WB_EN},   32'd0);
      checkOutput("to_err_set", {31'd0, mem_err}, 32'd1);
      checkOutput("to_alures",  {16'd0, ALURes},  32'h0100);
      checkOutput("to_req_off", {31'd0, mem_req}, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0055, 16'h0000, 4'd2);
      tick();
      tick();
      checkOutput("to_sticky",     {31'd0, mem_err}, 32'd1);
      checkOutput("to_after_nop",  {16'd0, ALURes},  32'h0055);

      // Reset in the second access cycle, then a late ack.
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0200, 16'h0000, 4'd9);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0);
      tick();
      checkOutput("rs_req_before", {31'd0, mem_req}, 32'd1);
      rst = 1'b1;
      tick();
      checkOutput("rs_req",    {31'd0, mem_req},  32'd0);
      checkOutput("rs_err",    {31'd0, mem_err},  32'd0);
      checkOutput("rs_wb_en",  {31'd0, WB_EN},    32'd0);
      checkOutput("rs_alures", {16'd0, ALURes},   32'd0);
      rst       = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 16'h7777;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      checkOutput("rs_late_wb",     {31'd0, WB_EN},    32'd0);
      checkOutput("rs_late_memres", {16'd0, MEMRes},   32'd0);
      checkOutput("rs_late_rden",   {31'd0, MEM_R_EN}, 32'd0);
      checkOutput("rs_late_req",    {31'd0, mem_req},  32'd0);
      checkOutput("rs_late_freeze", {31'd0, freeze},   32'd0);

      // Read and write together: write issued, error flagged.
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0300, 16'hA5A5, 4'd0);
      #1;
      checkOutput("il_freeze", {31'd0, freeze},  32'd1);
      checkOutput("il_err0",   {31'd0, mem_err}, 32'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0);
      checkOutput("il_err",   {31'd0, mem_err},   32'd1);
      checkOutput("il_we",    {31'd0, mem_we},    32'd1);
      checkOutput("il_req",   {31'd0, mem_req},   32'd1);
      checkOutput("il_wdata", {16'd0, mem_wdata}, 32'hA5A5);
      mem_ack = 1'b1;
      tick();
      checkOutput("il_rden", {31'd0, MEM_R_EN}, 32'd0);
      checkOutput("il_err2", {31'd0, mem_err},  32'd1);

      // Ack while idle is ignored.
      tick();
      checkOutput("ia_req",    {31'd0, mem_req}, 32'd0);
      checkOutput("ia_freeze", {31'd0, freeze},  32'd0);
      checkOutput("ia_memres", {16'd0, MEMRes},  32'd0);
      mem_ack = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
